// File: rtl/hist2d_acq_ctrl_if.sv
// Sample stream and hist2d strobe/ack signals shared by the acquisition sequencer
// (master) and its environment: upstream source plus hist2d (slave).
interface hist2d_acq_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_i;
    logic signed [DATA_W-1:0] s_q;
    logic                     h_data_in;
    logic signed [DATA_W-1:0] h_i_val;
    logic signed [DATA_W-1:0] h_q_val;
    logic                     h_bin_found;

    modport master (
        input  s_valid, s_i, s_q, h_bin_found,
        output s_ready, h_data_in, h_i_val, h_q_val
    );

    modport slave (
        output s_valid, s_i, s_q, h_bin_found,
        input  s_ready, h_data_in, h_i_val, h_q_val
    );
endinterface

// File: rtl/hist2d_acq_ctrl.sv
// Acquisition sequencer: pulls I/Q samples, strobes hist2d once per sample, waits for
// bin_found or timeout, enforces an inter-point gap and tracks progress counters.
module hist2d_acq_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned MIN_GAP     = 4
) (
    input  logic                 clk100,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 stream_mode,
    input  logic [CNT_W-1:0]     num_data_pts,
    hist2d_acq_ctrl_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_W-1:0]     pts_done,
    output logic [CNT_W-1:0]     timeout_cnt
);

    typedef enum logic [2:0] {
        IDLE, WAIT_SAMPLE, ISSUE, WAIT_ACK, GAP, DONE
    } state_t;

    localparam int unsigned    TMR_W    = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned    GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state;
    logic [CNT_W-1:0]   num_lat;
    logic               stream_lat;
    logic [TMR_W-1:0]   ack_tmr;
    logic [GAP_W-1:0]   gap_tmr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            num_lat       <= '0;
            stream_lat    <= 1'b0;
            ack_tmr       <= '0;
            gap_tmr       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            pts_done      <= '0;
            timeout_cnt   <= '0;
            bus.s_ready   <= 1'b0;
            bus.h_data_in <= 1'b0;
            bus.h_i_val   <= '0;
            bus.h_q_val   <= '0;
        end else begin
            bus.h_data_in <= 1'b0;
            aborted       <= 1'b0;
            if (state != IDLE && abort) begin
                state       <= IDLE;
                busy        <= 1'b0;
                done        <= 1'b0;
                bus.s_ready <= 1'b0;
                aborted     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            num_lat     <= num_data_pts;
                            stream_lat  <= stream_mode;
                            pts_done    <= '0;
                            timeout_cnt <= '0;
                            busy        <= 1'b1;
                            if (!stream_mode && num_data_pts == '0) begin
                                state <= DONE;
                            end else begin
                                state       <= WAIT_SAMPLE;
                                bus.s_ready <= 1'b1;
                            end
                        end
                    end
                    WAIT_SAMPLE: begin
                        if (bus.s_valid && bus.s_ready) begin
                            bus.h_i_val   <= bus.s_i;
                            bus.h_q_val   <= bus.s_q;
                            bus.s_ready   <= 1'b0;
                            bus.h_data_in <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        ack_tmr <= TMR_W'(ACK_TIMEOUT);
                        state   <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        // An ack on the expiry cycle wins over the timeout.
                        if (bus.h_bin_found) begin
                            pts_done <= sat_inc(pts_done);
                            gap_tmr  <= GAP_LOAD;
                            state    <= GAP;
                        end else if (ack_tmr <= TMR_W'(1)) begin
                            pts_done    <= sat_inc(pts_done);
                            timeout_cnt <= sat_inc(timeout_cnt);
                            gap_tmr     <= GAP_LOAD;
                            state       <= GAP;
                        end else begin
                            ack_tmr <= ack_tmr - TMR_W'(1);
                        end
                    end
                    GAP: begin
                        if (gap_tmr != '0) begin
                            gap_tmr <= gap_tmr - GAP_W'(1);
                        end else if (!stream_lat && pts_done == num_lat) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= WAIT_SAMPLE;
                            bus.s_ready <= 1'b1;
                        end
                    end
                    DONE: begin
                        // Arriving from GAP, done is already high; a zero-count run
                        // enters with done low and spends one extra cycle raising it.
                        if (done) begin
                            done  <= 1'b0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b0;
                        bus.s_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hist2d_acq_ctrl.sv
// Directed bench for hist2d_acq_ctrl: counted, timeout, backpressure, zero-count,
// stream/abort and reset/edge-case runs with hand-computed expectations.
module tb_hist2d_acq_ctrl;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic             rst_n;
    logic             start;
    logic             abort;
    logic             stream_mode;
    logic [CNT_W-1:0] num_data_pts;
    logic             busy, done, aborted;
    logic [CNT_W-1:0] pts_done, timeout_cnt;

    hist2d_acq_ctrl_if #(.DATA_W(DATA_W)) bus ();

    hist2d_acq_ctrl #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .ACK_TIMEOUT(64), .MIN_GAP(4)
    ) dut (
        .clk100(clk100), .rst_n(rst_n), .start(start), .abort(abort),
        .stream_mode(stream_mode), .num_data_pts(num_data_pts), .bus(bus),
        .busy(busy), .done(done), .aborted(aborted),
        .pts_done(pts_done), .timeout_cnt(timeout_cnt)
    );

    // Upstream source: samples [src_idx, src_len) are offered back to back.
    logic signed [DATA_W-1:0] src_i [64];
    logic signed [DATA_W-1:0] src_q [64];
    int unsigned src_idx = 0;
    int unsigned src_len = 0;
    assign bus.s_valid = (src_idx < src_len);
    assign bus.s_i     = src_i[src_idx[5:0]];
    assign bus.s_q     = src_q[src_idx[5:0]];
    always @(posedge clk100) if (bus.s_valid && bus.s_ready) src_idx <= src_idx + 1;

    int unsigned cyc = 0;
    always @(posedge clk100) cyc <= cyc + 1;

    // Strobe recorder and hist2d ack responder (ack lands 3 cycles after the strobe cycle).
    int unsigned              strobe_cnt = 0, n_done = 0, n_abrt = 0, ack_cd = 0;
    int unsigned              st_cyc [64];
    logic signed [DATA_W-1:0] st_i [64];
    logic signed [DATA_W-1:0] st_q [64];
    int unsigned              supp_idx = 32'hFFFF_FFFF;
    logic                     resp_ack = 1'b0, stray_ack = 1'b0;
    assign bus.h_bin_found = resp_ack | stray_ack;

    always @(negedge clk100) begin
        resp_ack = 1'b0;
        if (ack_cd != 0) begin
            ack_cd = ack_cd - 1;
            if (ack_cd == 0) resp_ack = 1'b1;
        end
        if (bus.h_data_in) begin
            st_cyc[strobe_cnt % 64] = cyc;
            st_i[strobe_cnt % 64]   = bus.h_i_val;
            st_q[strobe_cnt % 64]   = bus.h_q_val;
            if (strobe_cnt != supp_idx) ack_cd = 3;
            strobe_cnt = strobe_cnt + 1;
        end
        if (done)    n_done = n_done + 1;
        if (aborted) n_abrt = n_abrt + 1;
    end

    int unsigned n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk100);
        #1;
    endtask

    task automatic load(input int unsigned n, input int v0, input int qoff);
        for (int unsigned k = 0; k < n; k++) begin
            src_i[(src_len + k) % 64] = DATA_W'(v0 + int'(k));
            src_q[(src_len + k) % 64] = DATA_W'(v0 + int'(k) + qoff);
        end
        src_len = src_len + n;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n, input logic strm);
        start = 1'b1; num_data_pts = n; stream_mode = strm;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned k = 0;
        while (!done && k < budget) begin step(); k++; end
        chk("wait_done", done, 1'b1);
    endtask

    task automatic wait_strobes(input int unsigned target, input int unsigned budget);
        int unsigned k = 0;
        while (strobe_cnt < target && k < budget) begin step(); k++; end
        chk("wait_strobe", strobe_cnt >= target, 1'b1);
    endtask

    task automatic chk_vals(input int unsigned b, input int unsigned n, input int v0, input int qoff);
        for (int unsigned k = 0; k < n; k++) begin
            chk("strobe_i", st_i[(b + k) % 64], v0 + int'(k));
            chk("strobe_q", st_q[(b + k) % 64], v0 + int'(k) + qoff);
        end
    endtask

    function automatic int unsigned gap_of(input int unsigned idx);
        return st_cyc[idx % 64] - st_cyc[(idx - 1) % 64];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned b, d0, a0;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; stream_mode = 1'b0; num_data_pts = '0;
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_h_data_in", bus.h_data_in, 0);
        chk("rst_flags", {busy, done, aborted}, 0);
        chk("rst_h_val", {bus.h_i_val, bus.h_q_val}, 0);
        chk("rst_counters", {pts_done, timeout_cnt}, 0);
        rst_n = 1'b1;
        step();

        // Counted run: 5 points, I=Q=-3..1, ack 3 cycles after each strobe -> period 9.
        load(5, -3, 0);
        b = strobe_cnt; d0 = n_done;
        do_start(5, 1'b0);
        chk("run1_busy", busy, 1'b1);
        chk("run1_s_ready", bus.s_ready, 1'b1);
        wait_done(200);
        chk("run1_strobes", strobe_cnt - b, 5);
        chk_vals(b, 5, -3, 0);
        for (int unsigned k = 1; k < 5; k++) chk("run1_spacing", gap_of(b + k), 9);
        chk("run1_pts", pts_done, 5);
        chk("run1_tmo", timeout_cnt, 0);
        chk("run1_ndone", n_done - d0, 1);
        step();
        chk("run1_busy_low", {busy, done}, 2'b00);
        chk("run1_hold_i", bus.h_i_val, 1);

        // Timeout on point 2: strobe-to-strobe = 1 + 64 + 4 + 1 = 70 cycles.
        load(3, 10, 1000);
        b = strobe_cnt; supp_idx = b + 1;
        do_start(3, 1'b0);
        wait_done(400);
        supp_idx = 32'hFFFF_FFFF;
        chk("tmo_strobes", strobe_cnt - b, 3);
        chk_vals(b, 3, 10, 1000);
        chk("tmo_spacing1", gap_of(b + 1), 9);
        chk("tmo_spacing2", gap_of(b + 2), 70);
        chk("tmo_cnt", timeout_cnt, 1);
        chk("tmo_pts", pts_done, 3);
        step();

        // Backpressure: only one sample available, then 20+ idle cycles.
        load(1, 7, 1000);
        b = strobe_cnt;
        do_start(3, 1'b0);
        wait_strobes(b + 1, 50);
        repeat (22) step();
        chk("bp_no_strobe", strobe_cnt - b, 1);
        chk("bp_waiting", {busy, bus.s_ready}, 2'b11);
        load(2, 8, 1000);
        wait_done(200);
        chk("bp_strobes", strobe_cnt - b, 3);
        chk_vals(b, 3, 7, 1000);
        chk("bp_pts", pts_done, 3);
        step();

        // Zero count: done in N+2, busy low in N+3, no strobe.
        b = strobe_cnt; d0 = n_done;
        do_start(0, 1'b0);
        chk("zc_n1", {busy, done}, 2'b10);
        step();
        chk("zc_n2", {busy, done}, 2'b11);
        step();
        chk("zc_n3", {busy, done}, 2'b00);
        chk("zc_strobes", strobe_cnt - b, 0);
        chk("zc_ndone", n_done - d0, 1);
        chk("zc_pts", pts_done, 0);

        // Stream mode ignores the count of 2; abort during WAIT_ACK of point 7.
        load(7, 100, 1000);
        b = strobe_cnt; d0 = n_done; a0 = n_abrt;
        do_start(2, 1'b1);
        wait_strobes(b + 7, 200);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_flags", {aborted, busy, done, bus.s_ready}, 4'b1000);
        chk("ab_pts", pts_done, 6);
        repeat (5) step();
        chk("ab_pts_hold", pts_done, 6);
        chk("ab_strobes", strobe_cnt - b, 7);
        chk_vals(b, 7, 100, 1000);
        chk("ab_ndone", n_done - d0, 0);
        chk("ab_nabort", n_abrt - a0, 1);
        chk("ab_busy", busy, 0);

        // Start reissued while busy with a different count must be ignored.
        load(3, 50, 1000);
        b = strobe_cnt;
        do_start(3, 1'b0);
        step();
        do_start(1, 1'b0);
        wait_done(200);
        chk("rs_pts", pts_done, 3);
        chk("rs_strobes", strobe_cnt - b, 3);
        repeat (2) step();
        stray_ack = 1'b1;
        repeat (3) step();
        stray_ack = 1'b0;
        step();
        chk("stray_counters", {pts_done, timeout_cnt}, {16'd3, 16'd0});
        chk("stray_busy", busy, 0);

        // Reset asserted in GAP after the first point.
        load(3, 60, 1000);
        b = strobe_cnt; d0 = n_done;
        do_start(3, 1'b0);
        wait_strobes(b + 1, 50);
        repeat (5) step();
        chk("gap_pts_before", pts_done, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {busy, done, aborted, bus.s_ready, bus.h_data_in}, 0);
        chk("arst_counters", {pts_done, timeout_cnt}, 0);
        chk("arst_h_val", {bus.h_i_val, bus.h_q_val}, 0);
        step();
        step();
        rst_n = 1'b1;
        src_len = src_idx;
        repeat (20) step();
        chk("arst_ndone", n_done - d0, 0);
        chk("arst_idle", {busy, pts_done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
